// File: rtl/mul32_seq_if.sv
// Operand/result bundle for the sequential 32x32 unsigned multiplier.
// The master drives a request; the slave (mul32_seq) returns status and product.
interface mul32_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output product
  );
endinterface

// File: rtl/mul32_seq.sv
// Unsigned 32x32 shift-and-add multiplier: one add32, 32 RUN cycles per product.
// product is the live {hi,lo} accumulator, so it holds after DONE until the next start.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out
);
  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
endmodule

module mul32_seq (
  input  logic         clk,
  input  logic         rst,
  mul32_seq_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        busy;
  logic        done;

  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  cnt;

  logic [31:0] add_b;
  logic [31:0] add_s;
  logic        add_c;

  // Iteration counter advances with bitwise ripple logic so that add32 stays the only adder.
  function automatic logic [4:0] inc5(input logic [4:0] v);
    logic [4:0] r;
    logic       carry;
    carry = 1'b1;
    r     = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      r[i]  = v[i] ^ carry;
      carry = carry & v[i];
    end
    return r;
  endfunction

  // Adding zero when lo[0]=0 yields {0,hi}, matching the skip-add case exactly.
  assign add_b = lo[0] ? mcand : '0;

  add32 u_add32 (
    .a     (hi),
    .b     (add_b),
    .c_in  (1'b0),
    .s     (add_s),
    .c_out (add_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 5'd31) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Carry-out lands in bit 63 of the right-shifted 65-bit {c,s,lo}.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      mcand <= bus.a;
      hi    <= '0;
      lo    <= bus.b;
      cnt   <= '0;
    end else if (state == RUN) begin
      hi    <= {add_c, add_s[31:1]};
      lo    <= {add_s[0], lo[31:1]};
      cnt   <= inc5(cnt);
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = {hi, lo};
endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq against a plain a*b reference with a 33-edge latency.
module tb_mul32_seq;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mul32_seq_if bus ();

  mul32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start pulse and measures edges until done; operands are scrambled while running.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        output int lat, output logic [63:0] prod,
                        output int busy_cycles, output int overlap);
    lat         = -1;
    prod        = '0;
    busy_cycles = 0;
    overlap     = 0;
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    if (bus.busy) busy_cycles++;
    for (int i = 1; i <= 40; i++) begin
      tick();
      bus.a = $urandom;
      bus.b = $urandom;
      if (bus.busy && bus.done) overlap++;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        lat  = i;
        prod = bus.product;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat, bc, ov;
    logic [63:0] p;
    rst = 1'b0;
    bus.start = 1'b1;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'hFFFF_FFFF;
    repeat (3) tick();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0", bus.done);
    end
    n_checks++;
    if (bus.product !== 64'h0) begin
      n_fail++; $display("FAIL reset_product: got %h want 0", bus.product);
    end
    rst = 1'b1;
    run_op(32'd11, 32'd13, lat, p, bc, ov);
    n_checks++;
    if (lat !== 32) begin
      n_fail++; $display("FAIL first_start_latency: got %0d want 32", lat);
    end
    n_checks++;
    if (p !== 64'd143) begin
      n_fail++; $display("FAIL first_start_product: got %h want %h", p, 64'd143);
    end
    tick();
  endtask

  task automatic test_basic();
    int lat, bc, ov;
    logic [63:0] p;
    run_op(32'd3, 32'd5, lat, p, bc, ov);
    n_checks++;
    if (lat !== 32) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 32", lat);
    end
    n_checks++;
    if (bc !== 32) begin
      n_fail++; $display("FAIL basic_busy_cycles: got %0d want 32", bc);
    end
    n_checks++;
    if (p !== 64'h0000_0000_0000_000F) begin
      n_fail++; $display("FAIL basic_product: got %h want %h", p, 64'hF);
    end
    n_checks++;
    if (ov !== 0) begin
      n_fail++; $display("FAIL basic_busy_done_overlap: got %0d want 0", ov);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_single_cycle: got %b want 0", bus.done);
    end
    repeat (3) tick();
    n_checks++;
    if (bus.product !== 64'hF || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_product_hold: got %h busy %b want %h busy 0",
                         bus.product, bus.busy, 64'hF);
    end
  endtask

  task automatic test_max();
    int lat, bc, ov;
    logic [63:0] p;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p, bc, ov);
    n_checks++;
    if (p !== 64'hFFFF_FFFE_0000_0001 || lat !== 32) begin
      n_fail++; $display("FAIL max_product: got %h lat %0d want %h lat 32",
                         p, lat, 64'hFFFF_FFFE_0000_0001);
    end
    tick();
  endtask

  task automatic test_zero();
    int lat, bc, ov;
    logic [63:0] p;
    run_op(32'h1234_5678, 32'h0, lat, p, bc, ov);
    n_checks++;
    if (p !== 64'h0 || lat !== 32) begin
      n_fail++; $display("FAIL zero_b: got %h lat %0d want 0 lat 32", p, lat);
    end
    tick();
    run_op(32'h0, 32'hDEAD_BEEF, lat, p, bc, ov);
    n_checks++;
    if (p !== 64'h0 || lat !== 32) begin
      n_fail++; $display("FAIL zero_a: got %h lat %0d want 0 lat 32", p, lat);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [63:0] p;
    lat = -1;
    p   = '0;
    bus.start = 1'b1;
    bus.a     = 32'd7;
    bus.b     = 32'd9;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 10) begin
        bus.start = 1'b1;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done) begin
        lat = i;
        p   = bus.product;
        break;
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (lat !== 32) begin
      n_fail++; $display("FAIL ignored_start_latency: got %0d want 32", lat);
    end
    n_checks++;
    if (p !== 64'd63) begin
      n_fail++; $display("FAIL ignored_start_product: got %h want %h", p, 64'd63);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat, bc, ov, seen_done;
    logic [63:0] p;
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd100;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.product !== 64'h0) begin
      n_fail++; $display("FAIL abort_state: got busy %b product %h want busy 0 product 0",
                         bus.busy, bus.product);
    end
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done || bus.busy) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen_done);
    end
    run_op(32'd6, 32'd7, lat, p, bc, ov);
    n_checks++;
    if (p !== 64'd42 || lat !== 32) begin
      n_fail++; $display("FAIL abort_then_run: got %h lat %0d want %h lat 32", p, lat, 64'd42);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, bc, ov, bad;
    logic [31:0] x, y;
    logic [63:0] p;
    run_op(32'd5, 32'd6, lat, p, bc, ov);
    run_op(32'h8000_0000, 32'd2, lat, p, bc, ov);
    n_checks++;
    if (lat !== 32) begin
      n_fail++; $display("FAIL b2b_latency: got %0d want 32", lat);
    end
    n_checks++;
    if (p !== 64'h0000_0001_0000_0000) begin
      n_fail++; $display("FAIL b2b_product: got %h want %h", p, 64'h1_0000_0000);
    end
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      x = $urandom;
      y = $urandom;
      if (k % 8 == 0) x = 32'hFFFF_FFFF;
      if (k % 11 == 0) y = 32'hFFFF_FFFF;
      run_op(x, y, lat, p, bc, ov);
      n_checks++;
      if (p !== ref_mul(x, y) || lat !== 32 || ov !== 0 || bc !== 32) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random_%0d: a=%h b=%h got %h lat %0d busy %0d ov %0d want %h lat 32 busy 32",
                   k, x, y, p, lat, bc, ov, ref_mul(x, y));
        bad++;
      end
    end
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
